dmem_responder: RTL and testbench

Data-memory responder for the pipelined CPU: the memory-side end of the data-access interface that the memory stage drives. It accepts one load/store request at a time over a valid/ready handshake and holds it for a configurable number of wait cycles. It then performs a byte/halfword/word access on internal little-endian storage and returns a one-cycle response with read data or an error flag. It replaces the zero-latency combinational data memory so the pipeline can be exercised against multi-cycle memory.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, accesses little-endian word storage and returns a one-cycle response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; the response is a single-cycle strobe with no ready.
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          we_q, signed_q;
  logic [1:0]    size_q;
  logic [IW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic          in_idle, accept, req_err, do_access;
  logic          acc_we, acc_signed;
  logic [1:0]    acc_size;
  logic [IW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [IW-1:0] idx;
  logic [31:0]   rd_word, lane, load_val, wrep, wr_word;
  logic [3:0]    be;

  assign in_idle    = (state_q == ST_IDLE);
  assign req_ready  = in_idle & ~rst;
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = ~in_idle;
  assign dbg_state  = state_q;

  assign req_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b00) & (|req_addr[1:0]))
                 | ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  // With zero wait the access happens on the acceptance edge, straight from the inputs.
  assign acc_we     = in_idle ? req_we              : we_q;
  assign acc_size   = in_idle ? req_size            : size_q;
  assign acc_signed = in_idle ? req_signed          : signed_q;
  assign acc_addr   = in_idle ? req_addr[IW+1:0]    : addr_q;
  assign acc_wdata  = in_idle ? req_wdata           : wdata_q;

  assign do_access = (accept & ~req_err & (WAIT_CYCLES == 0))
                   | ((state_q == ST_WAIT) & (cnt_q == '0));

  assign idx     = acc_addr[IW+1:2];
  assign rd_word = mem_q[idx];
  assign lane    = rd_word >> {acc_addr[1:0], 3'b000};

  always_comb begin
    load_val = rd_word;
    wrep     = acc_wdata;
    be       = 4'b1111;
    case (acc_size)
      2'b01: begin
        load_val = acc_signed ? {{16{lane[15]}}, lane[15:0]} : {16'h0000, lane[15:0]};
        wrep     = {2{acc_wdata[15:0]}};
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        load_val = acc_signed ? {{24{lane[7]}}, lane[7:0]} : {24'h000000, lane[7:0]};
        wrep     = {4{acc_wdata[7:0]}};
        be       = 4'b0001 << acc_addr[1:0];
      end
      default: ;
    endcase
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = be[b] ? wrep[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            err_d   = 1'b0;
            rdata_d = req_we ? 32'h0 : load_val;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : load_val;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr[IW+1:0];
        wdata_q  <= req_wdata;
      end
    end
  end

  // Storage has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (do_access && acc_we) mem_q[idx] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic        req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;
  logic        req_ready0, resp_valid0, resp_err0, busy0;
  logic [31:0] resp_rdata0;
  logic [1:0]  dbg_state0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0), .dbg_state(dbg_state0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request to the selected instance, then check latency and response.
  task automatic do_req(input bit sel, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                        input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
    int guard;
    int lat;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    guard = 0;
    while (!(sel ? req_ready0 : req_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_valid0 = 1'b0;
    // scramble inputs: they must not matter after acceptance
    req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 2));
    req_signed = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!(sel ? resp_valid0 : resp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, sel ? resp_rdata0 : resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(sel ? resp_err0 : resp_err), 32'(exp_err));
  endtask

  initial begin
    int acc_t[$];
    int n_resp, bad, n_rv;
    bit drop;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(resp_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(req_ready), 32'd1);

    // word round trip
    do_req(0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, "st_w10", 32'h0, 0, 3);
    do_req(0, 0, 2'b00, 0, 32'h10, 32'h0, "ld_w10", 32'hDEADBEEF, 0, 3);

    // byte / halfword lanes
    do_req(0, 1, 2'b10, 0, 32'h21, 32'hFFFFFF80, "st_b21", 32'h0, 0, 3);
    do_req(0, 0, 2'b10, 1, 32'h21, 32'h0, "ld_bs21", 32'hFFFFFF80, 0, 3);
    do_req(0, 0, 2'b10, 0, 32'h21, 32'h0, "ld_bu21", 32'h00000080, 0, 3);
    do_req(0, 0, 2'b00, 1, 32'h20, 32'h0, "ld_w20a", 32'h00008000, 0, 3);
    do_req(0, 1, 2'b01, 0, 32'h22, 32'hABCD1234, "st_h22", 32'h0, 0, 3);
    do_req(0, 0, 2'b00, 0, 32'h20, 32'h0, "ld_w20b", 32'h12348000, 0, 3);
    do_req(0, 0, 2'b01, 1, 32'h20, 32'h0, "ld_hs20", 32'hFFFF8000, 0, 3);
    do_req(0, 0, 2'b01, 1, 32'h22, 32'h0, "ld_hs22", 32'h00001234, 0, 3);

    // last valid word
    do_req(0, 1, 2'b00, 0, 32'hFFC, 32'hA5A55A5A, "st_top", 32'h0, 0, 3);
    do_req(0, 0, 2'b00, 0, 32'hFFC, 32'h0, "ld_top", 32'hA5A55A5A, 0, 3);

    // error requests
    do_req(0, 0, 2'b01, 0, 32'h03, 32'h0, "err_h03", 32'h0, 1, 1);
    do_req(0, 1, 2'b00, 0, 32'h06, 32'hFFFFFFFF, "err_w06", 32'h0, 1, 1);
    do_req(0, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, "err_sz11", 32'h0, 1, 1);
    do_req(0, 1, 2'b00, 0, 32'h1000, 32'hFFFFFFFF, "err_range", 32'h0, 1, 1);
    do_req(0, 0, 2'b00, 0, 32'h04, 32'h0, "rb_w04", 32'h0, 0, 3);
    do_req(0, 0, 2'b00, 0, 32'h08, 32'h0, "rb_w08", 32'h0, 0, 3);
    do_req(0, 0, 2'b00, 0, 32'h20, 32'h0, "rb_w20", 32'h12348000, 0, 3);
    do_req(0, 0, 2'b00, 0, 32'h0, 32'h0, "rb_w00", 32'h0, 0, 3);

    // back-to-back loads with req_valid held
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    n_resp = 0; bad = 0; drop = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (drop) begin
        req_valid = 1'b0;
        drop = 1'b0;
      end
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() > 0) check("b2b_rdata", resp_rdata, exp_q.pop_front());
        else check("b2b_extra_resp", 32'(exp_q.size()), 32'd1);
      end
      if (req_valid && req_ready) begin
        acc_t.push_back(c);
        exp_q.push_back(32'hDEADBEEF);
        if (acc_t.size() == 3) drop = 1'b1;
      end else if (acc_t.size() > 0 && acc_t.size() < 3) begin
        if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
    end
    check("b2b_acc_count", 32'(acc_t.size()), 32'd3);
    if (acc_t.size() == 3) begin
      check("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd4);
      check("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd4);
    end
    check("b2b_busy_ready", 32'(bad), 32'd0);
    check("b2b_resp_count", 32'(n_resp), 32'd3);

    // reset while a store waits
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_addr = 32'h40; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rw_in_wait", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("rw_state", 32'(dbg_state), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_ready", 32'(req_ready), 32'd0);
    check("rw_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_rv = 0;
    repeat (6) begin
      if (resp_valid) n_rv++;
      @(negedge clk);
    end
    check("rw_no_resp", 32'(n_rv), 32'd0);
    do_req(0, 0, 2'b00, 0, 32'h40, 32'h0, "rw_ld40", 32'h0, 0, 3);
    do_req(0, 0, 2'b00, 0, 32'h10, 32'h0, "rw_ld10", 32'hDEADBEEF, 0, 3);

    // zero-wait instance
    do_req(1, 1, 2'b00, 0, 32'h0, 32'hCAFEF00D, "z_st0", 32'h0, 0, 1);
    do_req(1, 0, 2'b00, 0, 32'h0, 32'h0, "z_ld0", 32'hCAFEF00D, 0, 1);
    do_req(1, 0, 2'b10, 1, 32'h1, 32'h0, "z_lb1", 32'hFFFFFFF0, 0, 1);
    do_req(1, 0, 2'b00, 0, 32'h2, 32'h0, "z_err", 32'h0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
